// File: rtl/uart_text_console_if.sv
// Byte-stream and renderer read-port bundle for uart_text_console.
// The UART/renderer side uses master, the console uses slave.
interface uart_text_console_if #(
  parameter int AW = 6
);
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;

  modport master (output rx_data, output rx_valid, output rd_addr, input rd_data);
  modport slave  (input rx_data, input rx_valid, input rd_addr, output rd_data);
endinterface

// File: rtl/uart_text_console.sv
// ROWS x COLS text framebuffer fed by a UART byte stream: control codes, cursor, scroll.
// Optional TEXT_CURSOR_EN marks the cursor cell by setting rd_data[7] while idle.
module uart_text_console #(
  parameter int COLS = 16,
  parameter int ROWS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  uart_text_console_if.slave        bus,
  output logic [$clog2(ROWS)-1:0]   cursor_row,
  output logic [$clog2(COLS)-1:0]   cursor_col,
  output logic                      busy,
  output logic                      dirty,
  output logic                      overflow
);
  localparam int CELLS = ROWS * COLS;
  localparam int AW    = $clog2(CELLS);
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam logic [7:0] SPACE = 8'h20;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SCROLL} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [7:0]    pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic          dirty_q, dirty_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    rd_data_q, rd_data_d;

  logic [7:0]    mem [CELLS];
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;

  logic          idle, take_pend, take_rx, proc, last_cnt;
  logic [7:0]    byte_in;
  logic [AW-1:0] cur_addr;

  assign idle      = (state_q == S_IDLE);
  assign take_pend = idle && pend_v_q;
  assign take_rx   = idle && !pend_v_q && bus.rx_valid;
  assign proc      = take_pend || take_rx;
  assign byte_in   = pend_v_q ? pend_q : bus.rx_data;
  assign cur_addr  = AW'(int'(row_q) * COLS + int'(col_q));
  assign last_cnt  = (cnt_q == AW'(CELLS - 1));

  // The pending slot refills in the same cycle it drains, so a byte arriving
  // while the slot is being serviced is never lost.
  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    ovf_d    = ovf_q;
    if (take_pend) pend_v_d = 1'b0;
    if (bus.rx_valid && !take_rx) begin
      if (!pend_v_q || take_pend) begin
        pend_d   = bus.rx_data;
        pend_v_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    we      = 1'b0;
    waddr   = cur_addr;
    wdata   = SPACE;
    dirty_d = 1'b0;
    case (state_q)
      S_CLEAR: begin
        we    = 1'b1;
        waddr = cnt_q;
        cnt_d = cnt_q + 1'b1;
        if (last_cnt) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          row_d   = '0;
          col_d   = '0;
          dirty_d = 1'b1;
        end
      end
      S_SCROLL: begin
        // Upper rows copy from one row below; the final row is blanked.
        we    = 1'b1;
        waddr = cnt_q;
        wdata = (int'(cnt_q) < CELLS - COLS) ? mem[cnt_q + AW'(COLS)] : SPACE;
        cnt_d = cnt_q + 1'b1;
        if (last_cnt) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          row_d   = RW'(ROWS - 1);
          col_d   = '0;
          dirty_d = 1'b1;
        end
      end
      default: begin
        if (proc) begin
          if (byte_in >= 8'h20 && byte_in <= 8'h7E) begin
            we    = 1'b1;
            wdata = byte_in;
            if (col_q == CW'(COLS - 1)) begin
              col_d = '0;
              if (row_q == RW'(ROWS - 1)) state_d = S_SCROLL;
              else                        row_d   = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            case (byte_in)
              8'h08: begin
                // Linear address minus one covers both the in-row and row-wrap cases.
                waddr = cur_addr - AW'(1);
                if (col_q != '0) begin
                  col_d = col_q - 1'b1;
                  we    = 1'b1;
                end else if (row_q != '0) begin
                  row_d = row_q - 1'b1;
                  col_d = CW'(COLS - 1);
                  we    = 1'b1;
                end
              end
              8'h0D: col_d = '0;
              8'h0A: begin
                if (row_q == RW'(ROWS - 1)) state_d = S_SCROLL;
                else                        row_d   = row_q + 1'b1;
              end
              8'h0C:   state_d = S_CLEAR;
              default: ;
            endcase
          end
          dirty_d = (state_d == S_IDLE) && (we || row_d != row_q || col_d != col_q);
        end
      end
    endcase
  end

  always_comb begin
    rd_data_d = mem[bus.rd_addr];
`ifdef TEXT_CURSOR_EN
    if (idle && bus.rd_addr == cur_addr) rd_data_d[7] = 1'b1;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_CLEAR;
      cnt_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      pend_q    <= '0;
      pend_v_q  <= 1'b0;
      dirty_q   <= 1'b0;
      ovf_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
      dirty_q   <= dirty_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
    end
  end

  // NOTE: the framebuffer has no reset; the CLEAR pass after reset fills it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign bus.rd_data = rd_data_q;
  assign cursor_row  = row_q;
  assign cursor_col  = col_q;
  assign busy        = !idle;
  assign dirty       = dirty_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_uart_text_console.sv
// Self-checking bench for uart_text_console: byte-decode vector table, read-port
// scoreboard against a framebuffer model, and hand-written CLEAR/SCROLL/overflow sequences.
module tb_uart_text_console;
  localparam int COLS  = 16;
  localparam int ROWS  = 4;
  localparam int CELLS = ROWS * COLS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] cursor_row;
  logic [3:0] cursor_col;
  logic       busy, dirty, overflow;

  uart_text_console_if #(.AW(6)) bus ();

  uart_text_console #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy),
    .dirty      (dirty),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         addr;
    logic [7:0] data;
  } rd_exp_t;
  rd_exp_t sb_q[$];

  typedef struct {
    logic [7:0] b;
    int         row;
    int         col;
    bit         dirty;
  } vec_t;
  vec_t vecs[11];

  logic [7:0] model_mem [CELLS];
  int m_row, m_col;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < CELLS; i++) model_mem[i] = 8'h20;
    m_row = 0;
    m_col = 0;
  endtask

  task automatic model_scroll();
    for (int i = 0; i < CELLS - COLS; i++) model_mem[i] = model_mem[i + COLS];
    for (int i = CELLS - COLS; i < CELLS; i++) model_mem[i] = 8'h20;
    m_row = ROWS - 1;
    m_col = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      model_mem[m_row * COLS + m_col] = b;
      if (m_col == COLS - 1) begin
        m_col = 0;
        if (m_row == ROWS - 1) model_scroll();
        else m_row++;
      end else begin
        m_col++;
      end
    end else begin
      case (b)
        8'h08: begin
          if (m_col > 0) begin
            m_col--;
            model_mem[m_row * COLS + m_col] = 8'h20;
          end else if (m_row > 0) begin
            m_row--;
            m_col = COLS - 1;
            model_mem[m_row * COLS + m_col] = 8'h20;
          end
        end
        8'h0D: m_col = 0;
        8'h0A: if (m_row == ROWS - 1) model_scroll(); else m_row++;
        8'h0C: model_clear();
        default: ;
      endcase
    end
  endtask

  function automatic logic [7:0] model_cell(input int i);
    logic [7:0] v;
    v = model_mem[i];
`ifdef TEXT_CURSOR_EN
    if (i == m_row * COLS + m_col) v[7] = 1'b1;
`endif
    return v;
  endfunction

  // One byte per call; returns on the negedge right after the processing edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    model_byte(b);
  endtask

  task automatic check_cursor(input string name, input int row, input int col);
    check({name, "_row"}, cursor_row, row);
    check({name, "_col"}, cursor_col, col);
  endtask

  // Pipelined read of every cell: expected pushed at address issue, popped a cycle later.
  task automatic sweep(input string tag);
    rd_exp_t e;
    for (int i = 0; i <= CELLS; i++) begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check($sformatf("%s_rd%0d", tag, e.addr), bus.rd_data, e.data);
      end
      if (i < CELLS) begin
        bus.rd_addr = 6'(i);
        e.addr = i;
        e.data = model_cell(i);
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_timeout"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{8'h41, 0, 1,  1'b1};  // 'A'
    vecs[1]  = '{8'h42, 0, 2,  1'b1};  // 'B'
    vecs[2]  = '{8'h7F, 0, 2,  1'b0};  // DEL ignored
    vecs[3]  = '{8'h90, 0, 2,  1'b0};  // high byte ignored
    vecs[4]  = '{8'h0D, 0, 0,  1'b1};  // CR
    vecs[5]  = '{8'h08, 0, 0,  1'b0};  // BS at home: no-op
    vecs[6]  = '{8'h0A, 1, 0,  1'b1};  // LF
    vecs[7]  = '{8'h71, 1, 1,  1'b1};  // 'q'
    vecs[8]  = '{8'h08, 1, 0,  1'b1};  // BS in row
    vecs[9]  = '{8'h08, 0, 15, 1'b1};  // BS wraps to previous row
    vecs[10] = '{8'h0D, 0, 0,  1'b1};  // CR

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.rd_addr  = '0;
    model_clear();

    // Reset and initial CLEAR: busy for exactly 64 cycles after release.
    repeat (3) @(negedge clk);
    check("rst_rd_data", bus.rd_data, 8'h00);
    check("rst_busy", busy, 1'b1);
    check("rst_dirty", dirty, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    rst_n = 1'b1;
    repeat (63) @(negedge clk);
    check("clr_busy_63", busy, 1'b1);
    @(negedge clk);
    check("clr_busy_64", busy, 1'b0);
    check("clr_dirty_exit", dirty, 1'b1);
    check_cursor("clr", 0, 0);
    sweep("init");

    for (int i = 0; i < 11; i++) begin
      send(vecs[i].b);
      check_cursor($sformatf("v%0d", i), vecs[i].row, vecs[i].col);
      check($sformatf("v%0d_dirty", i), dirty, vecs[i].dirty);
      check($sformatf("v%0d_busy", i), busy, 1'b0);
    end
    sweep("tbl");

    // Form feed: 64-cycle CLEAR, dirty only on exit.
    send(8'h0C);
    check("ff_busy", busy, 1'b1);
    check("ff_dirty_busy", dirty, 1'b0);
    repeat (63) @(negedge clk);
    check("ff_busy_63", busy, 1'b1);
    @(negedge clk);
    check("ff_busy_64", busy, 1'b0);
    check("ff_dirty_exit", dirty, 1'b1);
    check_cursor("ff", 0, 0);

    for (int i = 0; i < 17; i++) send(8'h78);
    check_cursor("x17", 1, 1);
    send(8'h08);
    send(8'h08);
    check_cursor("bs2", 0, 15);
    sweep("xrow");

    // LF-driven scroll from the last row.
    send(8'h0D);
    send(8'h0A);
    send(8'h0A);
    send(8'h0A);
    check_cursor("lf3", 3, 0);
    send(8'h5A);
    check_cursor("z", 3, 1);
    send(8'h0A);
    check("scr_busy", busy, 1'b1);
    repeat (63) @(negedge clk);
    check("scr_busy_63", busy, 1'b1);
    @(negedge clk);
    check("scr_busy_64", busy, 1'b0);
    check("scr_dirty_exit", dirty, 1'b1);
    check_cursor("scr", 3, 0);
    send(8'h0D);
    check_cursor("cr", 3, 0);
    sweep("scr");

    // Character wrap at the last cell scrolls; two bytes arrive mid-scroll.
    for (int i = 0; i < 15; i++) send(8'h61 + 8'(i));
    @(negedge clk);
    bus.rx_data  = 8'h70;
    bus.rx_valid = 1'b1;
    model_byte(8'h70);
    @(negedge clk);
    bus.rx_data = 8'h50;
    @(negedge clk);
    bus.rx_data = 8'h51;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    check("ovf_busy", busy, 1'b1);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_dirty_busy", dirty, 1'b0);
    model_byte(8'h50);
    wait_idle("ovf", 200);
    repeat (2) @(negedge clk);
    check_cursor("pend", 3, 1);
    check("ovf_sticky", overflow, 1'b1);
    sweep("pend");

    // Reset in the middle of a CLEAR aborts it and clears the sticky flag.
    send(8'h0C);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_overflow", overflow, 1'b0);
    check("mid_rst_rd_data", bus.rd_data, 8'h00);
    check_cursor("mid_rst", 0, 0);
    rst_n = 1'b1;
    wait_idle("mid_rst", 200);
    sweep("rst2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
